// File: rtl/adc_spi_responder_pkg.sv
// Shared definitions for the emulated 12-bit / 8-channel SAR ADC SPI responder:
// frame length, command field positions, response word layout and FSM states.
package adc_spi_pkg;

  localparam int FRAME_BITS = 16;

  // Command word layout: [15] must be 0, [14:11] mode, [10:7] channel
  localparam logic [3:0] CMD_MODE_CTRL = 4'b0001;
  localparam int MODE_MSB = 14;
  localparam int MODE_LSB = 11;
  localparam int CHAN_MSB = 10;
  localparam int CHAN_LSB = 7;

  // Response word as shifted out on MISO, MSB first
  typedef struct packed {
    logic [3:0]  chan;
    logic [11:0] data;
  } resp_word_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_COMMIT
  } state_e;

  // A command requests a conversion only with the top bit clear and the control mode selected
  function automatic logic is_conversion(input logic [FRAME_BITS-1:0] cmd);
    return (cmd[FRAME_BITS-1] == 1'b0) && (cmd[MODE_MSB:MODE_LSB] == CMD_MODE_CTRL);
  endfunction

endpackage

// File: rtl/adc_spi_responder_if.sv
// SPI pin bundle between the ADC master and the emulated ADC responder.
// The master drives chip select, clock and command data; the responder drives MISO.
interface adc_spi_responder_if;
  import adc_spi_pkg::*;

  logic adc_csn;
  logic adc_sclk;
  logic adc_mosi;
  logic adc_miso;

  modport master (
    output adc_csn,
    output adc_sclk,
    output adc_mosi,
    input  adc_miso
  );

  modport slave (
    input  adc_csn,
    input  adc_sclk,
    input  adc_mosi,
    output adc_miso
  );

endinterface

// File: rtl/adc_spi_responder_spi_pin_sync.sv
// Brings one asynchronous SPI pin into the clk domain through SYNC_STAGES flops
// and flags rising/falling edges of the synchronized level. RESET_VAL is the pin's
// idle level so that releasing reset never fakes an edge.
module spi_pin_sync
  import adc_spi_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_d, sync_q;
  logic                   prev_d, prev_q;

  // Advance the synchronizer chain and remember the previous settled level
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = pin_i;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Synchronizer and edge-history registers
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = level_o & ~prev_q;
  assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/adc_spi_responder.sv
// SPI responder emulating a 12-bit, 8-channel SAR ADC with MAX11125-style framing.
// Each 16-bit frame shifts in a command and shifts out the response captured for the
// conversion requested in the previous frame.
// Optional build macro: ADC_RESP_CHAN_ID_EN tags the response with the channel
// number in bits [15:12]; without it those bits read zero.
module adc_spi_responder
  import adc_spi_pkg::*;
#(
  parameter int NCH         = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  adc_spi_responder_if.slave    spi,
  output logic [3:0]            sample_chan,
  input  logic [11:0]           sample_data,
  output logic                  frame_done,
  output logic [FRAME_BITS-1:0] last_cmd
);

  localparam logic [4:0] FRAME_CNT = 5'(FRAME_BITS);
  localparam logic [4:0] NCH_LIM   = 5'(NCH);

  logic csn_level_unused, csn_rise, csn_fall;
  logic sclk_level_unused, sclk_rise, sclk_fall;
  logic mosi_level, mosi_rise_unused, mosi_fall_unused;

  state_e                state_d, state_q;
  logic [4:0]            bitcnt_d, bitcnt_q;
  logic [FRAME_BITS-1:0] cmd_d, cmd_q;
  logic [FRAME_BITS-1:0] shift_d, shift_q;
  logic [FRAME_BITS-1:0] resp_d, resp_q;
  logic [FRAME_BITS-1:0] last_cmd_d, last_cmd_q;
  logic [3:0]            sample_chan_d, sample_chan_q;
  logic                  miso_d, miso_q;
  logic                  capture_d, capture_q;
  logic                  fall_pend_d, fall_pend_q;
  resp_word_t            resp_new;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_csn_sync (
    .clk     (clk),
    .reset   (reset),
    .pin_i   (spi.adc_csn),
    .level_o (csn_level_unused),
    .rise_o  (csn_rise),
    .fall_o  (csn_fall)
  );

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk     (clk),
    .reset   (reset),
    .pin_i   (spi.adc_sclk),
    .level_o (sclk_level_unused),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall)
  );

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi_sync (
    .clk     (clk),
    .reset   (reset),
    .pin_i   (spi.adc_mosi),
    .level_o (mosi_level),
    .rise_o  (mosi_rise_unused),
    .fall_o  (mosi_fall_unused)
  );

  // Build the response word from the currently selected channel; channels past NCH read zero data
  always_comb begin
    resp_new      = '0;
    resp_new.data = ({1'b0, sample_chan_q} < NCH_LIM) ? sample_data : 12'h000;
`ifdef ADC_RESP_CHAN_ID_EN
    resp_new.chan = sample_chan_q;
`else
    resp_new.chan = 4'h0;
`endif
  end

  // Frame FSM: next state, shift registers, MISO bit and commit side effects
  always_comb begin
    state_d       = state_q;
    bitcnt_d      = bitcnt_q;
    cmd_d         = cmd_q;
    shift_d       = shift_q;
    resp_d        = resp_q;
    last_cmd_d    = last_cmd_q;
    sample_chan_d = sample_chan_q;
    miso_d        = miso_q;
    capture_d     = 1'b0;
    fall_pend_d   = fall_pend_q;

    // The cycle after a conversion commit, sample_chan already points at the new channel
    if (capture_q) begin
      resp_d = resp_new;
    end

    unique case (state_q)
      ST_IDLE: begin
        miso_d = 1'b0;
        if (csn_fall || fall_pend_q) begin
          fall_pend_d = 1'b0;
          state_d     = ST_LOAD;
        end
      end

      ST_LOAD: begin
        shift_d  = resp_q;
        bitcnt_d = 5'd0;
        cmd_d    = '0;
        if (csn_rise) begin
          miso_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          miso_d  = resp_q[FRAME_BITS-1];
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (csn_rise) begin
          miso_d  = 1'b0;
          state_d = (bitcnt_q == FRAME_CNT) ? ST_COMMIT : ST_IDLE;
        end else if (sclk_rise) begin
          if (bitcnt_q < FRAME_CNT) begin
            cmd_d    = {cmd_q[FRAME_BITS-2:0], mosi_level};
            bitcnt_d = bitcnt_q + 5'd1;
          end else begin
            miso_d = 1'b0;
          end
        end else if (sclk_fall) begin
          if ((bitcnt_q != 5'd0) && (bitcnt_q < FRAME_CNT)) begin
            shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
            miso_d  = shift_q[FRAME_BITS-2];
          end
        end
      end

      ST_COMMIT: begin
        last_cmd_d = cmd_q;
        if (is_conversion(cmd_q)) begin
          sample_chan_d = cmd_q[CHAN_MSB:CHAN_LSB];
          capture_d     = 1'b1;
        end
        if (csn_fall) begin
          fall_pend_d = 1'b1;
        end
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      bitcnt_q      <= 5'd0;
      cmd_q         <= '0;
      shift_q       <= '0;
      resp_q        <= '0;
      last_cmd_q    <= '0;
      sample_chan_q <= 4'h0;
      miso_q        <= 1'b0;
      capture_q     <= 1'b0;
      fall_pend_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      bitcnt_q      <= bitcnt_d;
      cmd_q         <= cmd_d;
      shift_q       <= shift_d;
      resp_q        <= resp_d;
      last_cmd_q    <= last_cmd_d;
      sample_chan_q <= sample_chan_d;
      miso_q        <= miso_d;
      capture_q     <= capture_d;
      fall_pend_q   <= fall_pend_d;
    end
  end

  assign spi.adc_miso = miso_q;
  assign frame_done   = (state_q == ST_COMMIT);
  assign sample_chan  = sample_chan_q;
  assign last_cmd     = last_cmd_q;

endmodule
